// File: rtl/cbus_rr_arbiter_pkg.sv
// CBus request/response types and the arbiter's shared constants and helpers.
// Optional feature macro used by the arbiter: CBUS_ARB_ROUND_ROBIN_EN.
package cbus_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        MLEN1 = 2'd0,
        MLEN2 = 2'd1,
        MLEN4 = 2'd2,
        MLEN8 = 2'd3
    } cbus_len_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [2:0]  size;
        cbus_len_t   len;
        logic [3:0]  strobe;
        logic [31:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int CBUS_ARB_NUM_INPUTS = 2;

    // Index width that stays at least one bit even for a single requester.
    function automatic int cbus_arb_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cbus_rr_arbiter_if.sv
// Bundles the requester-side and shared-slave-side CBus signals of the arbiter.
// slave: the arbiter's view; master: the requesters plus the shared slave.
interface cbus_rr_arbiter_if
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int N = CBUS_ARB_NUM_INPUTS
);
    cbus_req_t  [N-1:0] ireqs;
    cbus_resp_t [N-1:0] iresps;
    cbus_req_t          oreq;
    cbus_resp_t         oresp;

    modport slave (
        input  ireqs,
        input  oresp,
        output iresps,
        output oreq
    );

    modport master (
        output ireqs,
        output oresp,
        input  iresps,
        input  oreq
    );
endinterface

// File: rtl/cbus_rr_select.sv
// Combinational wrap-around priority scan: first set bit of valid at or after start.
// start must be below N.
module cbus_rr_select #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] index
);
    logic [IDX_W-1:0] cand [N];
    logic [N-1:0]     hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [IDX_W:0] sum;
            assign sum       = {1'b0, start} + (IDX_W+1)'(gi);
            assign cand[gi]  = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                       : sum[IDX_W-1:0];
            assign hit[gi]   = valid[cand[gi]];
        end
    endgenerate

    // Walk from the farthest offset down so the nearest hit overwrites the rest.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (hit[k]) begin
                found = 1'b1;
                index = cand[k];
            end
        end
    end
endmodule

// File: rtl/cbus_rr_arbiter.sv
// Shares one CBus master port among NUM_INPUTS requesters, locking each grant until last.
// Define CBUS_ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index has fixed priority.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = CBUS_ARB_NUM_INPUTS
) (
    input  logic                 clk,
    input  logic                 reset,
    cbus_rr_arbiter_if.slave     bus
);
    localparam int IDX_W = cbus_arb_idx_w(NUM_INPUTS);

    arb_state_t             state_reg;
    logic [IDX_W-1:0]       owner_reg;
    logic [IDX_W-1:0]       start_idx;
    logic [NUM_INPUTS-1:0]  valid_mask;
    logic                   sel_found;
    logic [IDX_W-1:0]       sel_index;
    logic                   release_now;

`ifdef CBUS_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] ptr_next;
    assign start_idx = ptr_reg;
    assign ptr_next  = (owner_reg == IDX_W'(NUM_INPUTS - 1)) ? '0 : owner_reg + 1'b1;
`else
    assign start_idx = '0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_port
            assign valid_mask[gi] = bus.ireqs[gi].valid;
            // Non-owners see an all-zero response, which holds them off.
            assign bus.iresps[gi] = (state_reg == ARB_BUSY && owner_reg == IDX_W'(gi))
                                    ? bus.oresp : '0;
        end
    endgenerate

    assign bus.oreq    = (state_reg == ARB_BUSY) ? bus.ireqs[owner_reg] : '0;
    assign release_now = bus.oresp.ready && bus.oresp.last;

    cbus_rr_select #(
        .N     (NUM_INPUTS),
        .IDX_W (IDX_W)
    ) u_select (
        .valid (valid_mask),
        .start (start_idx),
        .found (sel_found),
        .index (sel_index)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ARB_IDLE;
            owner_reg <= '0;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            ptr_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (sel_found) begin
                        owner_reg <= sel_index;
                        state_reg <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // Only the final beat releases; earlier ready beats keep the lock.
                    if (release_now) begin
                        state_reg <= ARB_IDLE;
`ifdef CBUS_ARB_ROUND_ROBIN_EN
                        ptr_reg   <= ptr_next;
`endif
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Self-checking bench for cbus_rr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    localparam int N = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cbus_rr_arbiter_if #(.N(N)) bus();

    cbus_rr_arbiter #(.NUM_INPUTS(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model state: who holds the bus and where the next scan starts.
    bit m_busy = 1'b0;
    int m_owner = 0;
    int m_ptr = 0;
    int m_win;
    logic [N-1:0] m_mask;

    function automatic int pick(input logic [N-1:0] v, input int start);
        int best;
        int bestd;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                int d;
                d = (i - start + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) m_mask[i] = bus.ireqs[i].valid;
        if (reset) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_ptr   = 0;
        end else if (!m_busy) begin
`ifdef CBUS_ARB_ROUND_ROBIN_EN
            m_win = pick(m_mask, m_ptr);
`else
            m_win = pick(m_mask, 0);
`endif
            if (m_win >= 0) begin
                m_busy  = 1'b1;
                m_owner = m_win;
            end
        end else if (bus.oresp.ready && bus.oresp.last) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
        end
    end

    cbus_req_t              exp_oreq;
    cbus_resp_t [N-1:0]     exp_iresps;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_oreq = m_busy ? bus.ireqs[m_owner] : '0;
            for (int j = 0; j < N; j++)
                exp_iresps[j] = (m_busy && j == m_owner) ? bus.oresp : '0;
            tests++;
            if (bus.oreq !== exp_oreq) begin
                fails++;
                $display("FAIL model_oreq t=%0t got %h required %h", $time, bus.oreq, exp_oreq);
            end
            tests++;
            if (bus.iresps !== exp_iresps) begin
                fails++;
                $display("FAIL model_iresps t=%0t got %h required %h", $time, bus.iresps, exp_iresps);
            end
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s t=%0t got %0h required %0h", name, $time, got, req);
        end
    endtask

    function automatic cbus_req_t mk_req(input logic [31:0] addr, input cbus_len_t len);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = $urandom_range(0, 1) == 1;
        r.addr     = addr;
        r.size     = 3'd2;
        r.len      = len;
        r.strobe   = 4'($urandom_range(0, 15));
        r.data     = $urandom;
        return r;
    endfunction

    function automatic cbus_resp_t mk_resp(input logic ready, input logic last, input logic [31:0] data);
        cbus_resp_t r;
        r.ready = ready;
        r.last  = last;
        r.data  = data;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    int grants [4];
    int exp_grants [4];
    int ng;
    int beat;
    bit done [N];
    int txn_count;

    initial begin
        bus.ireqs = '0;
        bus.oresp = '0;
        reset     = 1'b1;
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        reset = 1'b0;

        // Idle after reset: nothing requested, nothing granted.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_oreq_valid", 128'(bus.oreq.valid), 128'(1'b0));
            check("idle_iresps_zero", 128'(bus.iresps), 128'(0));
            next_cycle();
        end
        $display("[TB] txn idle-after-reset checked");

        // Single-beat read by req0.
        bus.ireqs[0] = mk_req(32'h1000, MLEN1);
        @(negedge clk);
        check("grant_latency_t0", 128'(bus.oreq.valid), 128'(1'b0));
        next_cycle();
        bus.oresp = mk_resp(1'b1, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        check("single_oreq_addr", 128'(bus.oreq.addr), 128'(32'h1000));
        check("single_oreq_valid", 128'(bus.oreq.valid), 128'(1'b1));
        check("single_iresp0_data", 128'(bus.iresps[0].data), 128'(32'hDEADBEEF));
        check("single_iresp1_zero", 128'(bus.iresps[1]), 128'(0));
        next_cycle();
        bus.ireqs[0] = '0;
        bus.oresp    = '0;
        @(negedge clk);
        check("single_release_idle", 128'(bus.oreq.valid), 128'(1'b0));
        $display("[TB] txn single-beat req0 addr 1000 data deadbeef");
        pulse_reset();

        // Both requesters continuously valid, single-beat transactions.
`ifdef CBUS_ARB_ROUND_ROBIN_EN
        exp_grants = '{0, 1, 0, 1};
`else
        exp_grants = '{0, 0, 0, 0};
`endif
        bus.ireqs[0] = mk_req(32'hA000, MLEN1);
        bus.ireqs[1] = mk_req(32'hB000, MLEN1);
        ng = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            next_cycle();
            bus.oresp = bus.oreq.valid ? mk_resp(1'b1, 1'b1, $urandom) : '0;
            @(negedge clk);
            if (bus.oreq.valid) begin
                grants[ng] = (bus.oreq.addr == 32'hA000) ? 0 : 1;
                $display("[TB] txn alternating grant %0d -> req%0d", ng, grants[ng]);
                ng++;
            end
        end
        check("alt_grant_count", 128'(ng), 128'(4));
        for (int k = 0; k < 4; k++)
            check($sformatf("alt_grant_%0d", k), 128'(grants[k]), 128'(exp_grants[k]));
        next_cycle();
        bus.ireqs = '0;
        bus.oresp = '0;
        pulse_reset();

        // 4-beat burst from req0 with req1 waiting.
        bus.ireqs[0] = mk_req(32'hC000, MLEN4);
        bus.ireqs[1] = mk_req(32'hD000, MLEN1);
        for (int b = 0; b < 4; b++) begin
            next_cycle();
            bus.oresp = mk_resp(1'b1, b == 3, 32'(b));
            @(negedge clk);
            check($sformatf("burst_owner_beat%0d", b), 128'(bus.oreq.addr), 128'(32'hC000));
            check($sformatf("burst_iresp1_beat%0d", b), 128'(bus.iresps[1]), 128'(0));
        end
        next_cycle();
        bus.ireqs[0] = '0;
        bus.oresp    = '0;
        @(negedge clk);
        check("burst_gap_idle", 128'(bus.oreq.valid), 128'(1'b0));
        next_cycle();
        bus.oresp = mk_resp(1'b1, 1'b1, 32'h5555);
        @(negedge clk);
        check("burst_next_grant", 128'(bus.oreq.addr), 128'(32'hD000));
        $display("[TB] txn burst req0 4 beats then req1");
        next_cycle();
        bus.ireqs = '0;
        bus.oresp = '0;
        pulse_reset();

        // Reset in the middle of a burst aborts it and clears the scan start.
        bus.ireqs[0] = mk_req(32'hE000, MLEN1);
        next_cycle();
        bus.oresp = mk_resp(1'b1, 1'b1, 32'h1);
        @(negedge clk);
        check("abort_pre_owner", 128'(bus.oreq.addr), 128'(32'hE000));
        next_cycle();
        bus.ireqs[0] = '0;
        bus.ireqs[1] = mk_req(32'hF000, MLEN4);
        bus.oresp    = '0;
        next_cycle();
        bus.oresp = mk_resp(1'b1, 1'b0, 32'h2);
        @(negedge clk);
        check("abort_burst_owner", 128'(bus.oreq.addr), 128'(32'hF000));
        next_cycle();
        reset        = 1'b1;
        bus.oresp    = mk_resp(1'b1, 1'b0, 32'h3);
        bus.ireqs[0] = mk_req(32'hE100, MLEN1);
        next_cycle();
        reset     = 1'b0;
        bus.oresp = '0;
        @(negedge clk);
        check("abort_oreq_valid", 128'(bus.oreq.valid), 128'(1'b0));
        check("abort_iresps_zero", 128'(bus.iresps), 128'(0));
        next_cycle();
        @(negedge clk);
        check("abort_lowest_first", 128'(bus.oreq.addr), 128'(32'hE100));
        $display("[TB] txn reset mid-burst, regrant to req0");
        next_cycle();
        bus.ireqs = '0;
        pulse_reset();

        // Randomized traffic; the per-cycle model comparison does the checking.
        beat      = 0;
        txn_count = 0;
        for (int i = 0; i < N; i++) done[i] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            for (int i = 0; i < N; i++) begin
                if (!bus.ireqs[i].valid || done[i]) begin
                    if ($urandom_range(0, 3) != 0)
                        bus.ireqs[i] = mk_req($urandom & 32'hFFFF_FFFC, cbus_len_t'($urandom_range(0, 3)));
                    else
                        bus.ireqs[i] = '0;
                end
            end
            reset = ($urandom_range(0, 199) == 0);
            bus.oresp.data = $urandom;
            if (bus.oreq.valid) begin
                bus.oresp.ready = ($urandom_range(0, 2) != 0);
                bus.oresp.last  = bus.oresp.ready && (beat == (1 << int'(bus.oreq.len)) - 1);
            end else begin
                bus.oresp.ready = 1'($urandom_range(0, 1));
                bus.oresp.last  = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                done[i] = bus.iresps[i].ready && bus.iresps[i].last;
                if (done[i]) begin
                    txn_count++;
                    $display("[TB] txn random req%0d addr %h len %0d complete",
                             i, bus.ireqs[i].addr, 1 << int'(bus.ireqs[i].len));
                end
            end
            if (reset)
                beat = 0;
            else if (bus.oreq.valid && bus.oresp.ready)
                beat = bus.oresp.last ? 0 : beat + 1;
        end
        tests++;
        if (txn_count < 50) begin
            fails++;
            $display("FAIL random_progress got %0d transactions required at least 50", txn_count);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cbus_rr_arbiter.md
# cbus_rr_arbiter

Shares one CBus master port among `NUM_INPUTS` CBus requesters, typically the instruction-side and data-side bus adapters feeding the single memory/uncached CBus. It grants at most one requester at a time and holds the grant for the whole transaction, including all burst beats, until the beat with `last`. Requesters are selected round-robin, or by fixed priority when configured that way.

## Interface
- `NUM_INPUTS`, default 2: number of requesters, ≥1.
- `clk` input, 1: clock, all state updates on rising edge.
- `reset` input, 1: synchronous, active-high reset.
- `ireqs` input, `cbus_req_t [NUM_INPUTS-1:0]`: requester-side requests.
- `iresps` output, `cbus_resp_t [NUM_INPUTS-1:0]`: requester-side responses.
- `oreq` output, `cbus_req_t`: request to the shared CBus slave.
- `oresp` input, `cbus_resp_t`: response from the shared slave.

## Operation
- State: `busy` (1 bit), `owner` (IDX_W bits), `ptr` (IDX_W bits). IDX_W = max(1, $clog2(NUM_INPUTS)).
- IDLE (`busy`=0):
  - Pick the first `i` with `ireqs[i].valid`, scanning from `ptr` upward with wrap (round-robin build).
  - If one is found: `owner`←i and `busy`←1 at the next edge.
  - If none is valid, stay in IDLE.
- BUSY (`busy`=1):
  - `oreq` = `ireqs[owner]`, all fields passed through unmodified, including `len` and `strobe`.
  - `iresps[owner]` = `oresp`.
  - `iresps[j]` = all-zero for every j≠owner.
- Release: in BUSY, `oresp.ready && oresp.last` at an edge sets `busy`←0 and `ptr`←owner+1, wrapping NUM_INPUTS-1→0.
- A burst stays locked. Beats with `ready`=1 and `last`=0 never change the owner.
- Requesters keep `valid` and the request fields stable until they observe `ready && last`. If the owner drops `valid` mid-transaction, the arbiter stays BUSY with the same owner and `oreq.valid` follows the owner's `valid`. The arbiter does not time out.
- Non-owner requesters are held off because their responses read zero. They are not reordered or queued.
- A new request arriving in the same cycle as a release is not granted in that cycle. It is arbitrated in the following IDLE cycle.
- NUM_INPUTS=1: `ptr` is constant 0 and behaviour reduces to an idle/busy pass-through with one cycle of grant latency.

## Timing
- Reset (synchronous): `busy`=0, `owner`=0, `ptr`=0. `oreq` is all-zero and all `iresps` are all-zero in the cycle after reset is sampled.
- Reset asserted mid-transaction aborts the grant: next cycle is IDLE and the outputs are zero. The slave is expected to be reset by the same signal.
- `oreq` and `iresps` are combinational from the registered `busy`/`owner` and the current `ireqs`/`oresp`. There is no registered data path.
- In IDLE, `oreq` is all-zero, so `oreq.valid`=0.
- Grant latency: `ireqs[i].valid` first high in IDLE at cycle t gives `oreq.valid`=1 at t+1.
- Back-to-back: `ready && last` at cycle t gives IDLE at t+1 and the next grant's `oreq.valid` at t+2.
- Single-beat transaction: at least 2 cycles from valid to `ready && last` if the slave answers in the first granted cycle.

## Configuration
- `CBUS_ARB_ROUND_ROBIN_EN`:
  - Defined: the scan starts at `ptr` and `ptr` advances on every release, as described above.
  - Undefined: fixed priority. The lowest index wins, `ptr` is removed, and the scan always starts at 0. Every other behaviour is identical.

## Structure
- `cbus_req_t` and `cbus_resp_t` come from the existing common package, unchanged.
- Add to the shared package:
  - a helper function for IDX_W = max(1, $clog2(n)),
  - a localparam default `CBUS_ARB_NUM_INPUTS = 2`.
- One sub-module, `cbus_rr_select`: combinational. Inputs are a `valid` mask and a start index. Outputs are `found` and `index`, using a wrap-around priority scan. The top module instantiates it once, with the start index tied to 0 when `CBUS_ARB_ROUND_ROBIN_EN` is undefined.

## Test plan
- Reset, then all `ireqs.valid`=0 for 10 cycles → `oreq.valid`=0 and every `iresps` all-zero throughout.
- NUM_INPUTS=2, req0 single-beat read of addr 0x1000 at t=0; slave replies `ready`=1, `last`=1, data 0xDEADBEEF at t=1 → `oreq.addr`=0x1000 at t=1 and `iresps[0].data`=0xDEADBEEF at t=1; `iresps[1]` stays zero.
- Both requesters valid continuously, each transaction single-beat (round-robin build) → grants alternate 0,1,0,1. With the macro undefined → always 0 while req0 stays valid.
- req0 issues a 4-beat read burst (`len`=MLEN4) while req1 is valid → owner stays 0 through 3 non-last ready beats, and req1 is granted only 2 cycles after the 4th beat (`last`).
- `reset` asserted on the 2nd beat of a burst → next cycle `oreq.valid`=0, `ptr`=0, and the first grant after reset goes to the lowest valid index.
